// File: rtl/prioritized_arbiter_sched_pkg.sv
// Shared types and sizing helpers for the prioritized arbiter.
package prioritized_arbiter_pkg;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} arb_state_e;

  // Width of an aging counter able to hold 0..limit, never narrower than 1 bit.
  function automatic int cnt_width(input int unsigned limit);
    int w;
    w = $clog2(limit + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // Width of a requester index for n requesters, never narrower than 1 bit.
  function automatic int id_width(input int unsigned n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/prioritized_arbiter_sched_if.sv
// Requester/sink bundle of the prioritized arbiter.
// master: the arbiter side; slave: requesters plus downstream sink.
interface prioritized_arbiter_sched_if
  import prioritized_arbiter_pkg::*;
#(
  parameter int unsigned data_width       = 8,
  parameter int unsigned number_of_inputs = 4
);
  localparam int IW = id_width(number_of_inputs);

  logic [number_of_inputs-1:0]                 req_valid;
  logic [number_of_inputs-1:0][data_width-1:0] req_data;
  logic [number_of_inputs-1:0]                 req_ready;
  logic                                        out_valid;
  logic [data_width-1:0]                       out_data;
  logic                                        out_ready;
  logic [IW-1:0]                               grant_id;
  logic                                        grant_aged;

  modport master (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, grant_id, grant_aged
  );

  modport slave (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, grant_id, grant_aged
  );
endinterface

// File: rtl/prioritized_arbiter_sched_prio_pick.sv
// Combinational fixed-priority picker: first set mask bit in priority_list order.
module prio_pick
  import prioritized_arbiter_pkg::*;
#(
  parameter int unsigned number_of_inputs = 4,
  parameter int unsigned priority_list [number_of_inputs-1:0] = '{default: 0}
)(
  input  logic [number_of_inputs-1:0]           mask,
  output logic                                  found,
  output logic [id_width(number_of_inputs)-1:0] idx
);
  localparam int IW = id_width(number_of_inputs);

  // Scan from lowest rank up so the highest-ranked hit is written last and wins.
  always_comb begin
    logic [IW-1:0] p;
    found = 1'b0;
    idx   = '0;
    p     = '0;
    for (int r = number_of_inputs - 1; r >= 0; r--) begin
      p = IW'(priority_list[r]);
      if (mask[p]) begin
        found = 1'b1;
        idx   = p;
      end
    end
  end
endmodule

// File: rtl/prioritized_arbiter_sched.sv
// Starvation-safe fixed-priority arbiter with one registered output stage.
// Aged (starved) requesters override the static priority; the held word
// is kept until the sink takes it, and reload happens in the same edge.
module prioritized_arbiter_sched
  import prioritized_arbiter_pkg::*;
#(
  parameter int unsigned data_width       = 8,
  parameter int unsigned number_of_inputs = 4,
  parameter int unsigned priority_list [number_of_inputs-1:0] = '{3, 1, 2, 0},
  parameter int unsigned starvation_limit = 8
)(
  input logic clk,
  input logic rst_n,
  prioritized_arbiter_sched_if.master bus
);
  localparam int N  = number_of_inputs;
  localparam int IW = id_width(N);
  localparam int CW = cnt_width(starvation_limit);

  arb_state_e             st;
  logic [N-1:0][CW-1:0]   wait_cnt;
  logic [N-1:0]           starved;
  logic                   s_found, v_found;
  logic [IW-1:0]          s_idx, v_idx, w;
  logic                   aged, load;
  logic [N-1:0]           ready;
  logic [data_width-1:0]  out_data_q;
  logic [IW-1:0]          grant_id_q;
  logic                   grant_aged_q;

  // A requester is starved once its wait count reaches the limit (limit 0 disables).
  always_comb begin
    for (int i = 0; i < N; i++)
      starved[i] = (starvation_limit != 0) && bus.req_valid[i] &&
                   (wait_cnt[i] == CW'(starvation_limit));
  end

  prio_pick #(.number_of_inputs(N), .priority_list(priority_list)) u_pick_starved (
    .mask(starved), .found(s_found), .idx(s_idx)
  );

  prio_pick #(.number_of_inputs(N), .priority_list(priority_list)) u_pick_valid (
    .mask(bus.req_valid), .found(v_found), .idx(v_idx)
  );

  // Aging override takes precedence over static priority; rst_n gates accepts during reset.
  always_comb begin
    aged = s_found;
    w    = s_found ? s_idx : v_idx;
    load = rst_n && v_found && (st == EMPTY || bus.out_ready);
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      assign ready[gi] = load && (w == IW'(gi));

      // Per-requester wait counter: clears on idle or accept, else saturating count.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          wait_cnt[gi] <= '0;
        else if (!bus.req_valid[gi] || ready[gi])
          wait_cnt[gi] <= '0;
        else if (wait_cnt[gi] != CW'(starvation_limit))
          wait_cnt[gi] <= wait_cnt[gi] + 1'b1;
      end
    end
  endgenerate

  // Output stage FSM: load (possibly over a draining word), drain, or hold on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st           <= EMPTY;
      out_data_q   <= '0;
      grant_id_q   <= '0;
      grant_aged_q <= 1'b0;
    end else begin
      case (st)
        EMPTY: begin
          if (load) begin
            out_data_q   <= bus.req_data[w];
            grant_id_q   <= w;
            grant_aged_q <= aged;
            st           <= FULL;
          end
        end
        FULL: begin
          if (load) begin
            out_data_q   <= bus.req_data[w];
            grant_id_q   <= w;
            grant_aged_q <= aged;
          end else if (bus.out_ready) begin
            st <= EMPTY;
          end
        end
        default: st <= EMPTY;
      endcase
    end
  end

  assign bus.req_ready  = ready;
  assign bus.out_valid  = (st == FULL);
  assign bus.out_data   = out_data_q;
  assign bus.grant_id   = grant_id_q;
  assign bus.grant_aged = grant_aged_q;

endmodule
